// File: rtl/raw_column_reader_if.sv
// Byte-in / column-out stream bundle for raw_column_reader.
//   master : byte producer and column sink side (drives byte_*, col_ready)
//   slave  : the column reader itself (drives byte_ready, col_*, err_short)
interface raw_column_reader_if #(
    parameter int unsigned PIPELINE_HEIGHT = 5,
    parameter int unsigned COLOR_WIDTH     = 8,
    parameter int unsigned INDEX_WIDTH     = 16
);
    localparam int unsigned COL_W = PIPELINE_HEIGHT * 3 * COLOR_WIDTH;

    // Byte stream
    logic                   byte_valid;
    logic [COLOR_WIDTH-1:0] byte_data;
    logic                   byte_last;
    logic                   byte_ready;

    // Column stream
    logic                   col_valid;
    logic                   col_ready;
    logic [COL_W-1:0]       col_pixels;
    logic                   col_last;
    logic [INDEX_WIDTH-1:0] col_index;

    // Sticky short-frame status
    logic                   err_short;

    modport master (
        output byte_valid, byte_data, byte_last, col_ready,
        input  byte_ready, col_valid, col_pixels, col_last, col_index, err_short
    );

    modport slave (
        input  byte_valid, byte_data, byte_last, col_ready,
        output byte_ready, col_valid, col_pixels, col_last, col_index, err_short
    );
endinterface

// File: rtl/raw_column_reader.sv
// raw_column_reader: reassembles an R,G,B byte stream into columns of
// PIPELINE_HEIGHT pixels for the head of the image pipeline.
// Ports:
//   clock   - system clock, rising edge
//   reset_n - asynchronous active-low reset
//   bus     - slave side of raw_column_reader_if (byte in, column out,
//             sticky err_short)
// Pixel p of col_pixels sits at [p*3W +: 3W], red in the top byte.
module raw_column_reader #(
    parameter int unsigned PIPELINE_HEIGHT = 5,
    parameter int unsigned COLOR_WIDTH     = 8,
    parameter int unsigned INDEX_WIDTH     = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    raw_column_reader_if.slave    bus
);
    localparam int unsigned PIX_W = 3 * COLOR_WIDTH;
    localparam int unsigned COL_W = PIPELINE_HEIGHT * PIX_W;
    localparam int unsigned PTR_W = (PIPELINE_HEIGHT > 1) ? $clog2(PIPELINE_HEIGHT) : 1;

    // Channel encoding: 0 = R, 1 = G, 2 = B
    logic [1:0]             chan_q, chan_d;
    logic [PTR_W-1:0]       pix_q, pix_d;
    logic [COL_W-1:0]       stage_q, stage_d;
    logic                   col_valid_q, col_valid_d;
    logic [COL_W-1:0]       col_pixels_q, col_pixels_d;
    logic                   col_last_q, col_last_d;
    logic [INDEX_WIDTH-1:0] col_index_q, col_index_d;
    logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;
    logic                   err_short_q, err_short_d;

    logic                   byte_ready_c;
    logic                   accept_c;
    logic                   col_final_c;
    logic [COL_W-1:0]       merged_c;

    // Intake stalls whenever an unaccepted column is held
    assign byte_ready_c = !col_valid_q || bus.col_ready;
    assign accept_c     = bus.byte_valid && byte_ready_c;
    assign col_final_c  = (pix_q == PTR_W'(PIPELINE_HEIGHT - 1)) && (chan_q == 2'd2);

    // Staging buffer with the incoming byte dropped into its slot
    always_comb begin
        merged_c = stage_q;
        for (int p = 0; p < int'(PIPELINE_HEIGHT); p++) begin
            for (int c = 0; c < 3; c++) begin
                if (pix_q == PTR_W'(p) && chan_q == 2'(c)) begin
                    merged_c[p*int'(PIX_W) + (2-c)*int'(COLOR_WIDTH) +: COLOR_WIDTH] = bus.byte_data;
                end
            end
        end
    end

    // Next-state: byte intake, column load, output handshake
    always_comb begin
        chan_d       = chan_q;
        pix_d        = pix_q;
        stage_d      = stage_q;
        col_valid_d  = col_valid_q;
        col_pixels_d = col_pixels_q;
        col_last_d   = col_last_q;
        col_index_d  = col_index_q;
        cnt_d        = cnt_q;
        err_short_d  = err_short_q;

        if (col_valid_q && bus.col_ready) begin
            col_valid_d = 1'b0;
        end

        if (accept_c) begin
            if (col_final_c || bus.byte_last) begin
                // Column complete or frame ended: load output, restart column
                col_valid_d  = 1'b1;
                col_pixels_d = merged_c;
                col_last_d   = bus.byte_last;
                col_index_d  = cnt_q;
                cnt_d        = bus.byte_last ? '0 : cnt_q + INDEX_WIDTH'(1);
                stage_d      = '0;
                chan_d       = 2'd0;
                pix_d        = '0;
                if (bus.byte_last && !col_final_c) begin
                    err_short_d = 1'b1;
                end
            end else begin
                stage_d = merged_c;
                if (chan_q == 2'd2) begin
                    chan_d = 2'd0;
                    pix_d  = pix_q + PTR_W'(1);
                end else begin
                    chan_d = chan_q + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            chan_q       <= 2'd0;
            pix_q        <= '0;
            stage_q      <= '0;
            col_valid_q  <= 1'b0;
            col_pixels_q <= '0;
            col_last_q   <= 1'b0;
            col_index_q  <= '0;
            cnt_q        <= '0;
            err_short_q  <= 1'b0;
        end else begin
            chan_q       <= chan_d;
            pix_q        <= pix_d;
            stage_q      <= stage_d;
            col_valid_q  <= col_valid_d;
            col_pixels_q <= col_pixels_d;
            col_last_q   <= col_last_d;
            col_index_q  <= col_index_d;
            cnt_q        <= cnt_d;
            err_short_q  <= err_short_d;
        end
    end

    assign bus.byte_ready = byte_ready_c;
    assign bus.col_valid  = col_valid_q;
    assign bus.col_pixels = col_pixels_q;
    assign bus.col_last   = col_last_q;
    assign bus.col_index  = col_index_q;
    assign bus.err_short  = err_short_q;
endmodule

// File: tb/tb_raw_column_reader.sv
// Testbench for raw_column_reader: directed scenarios plus random frames,
// compared against a byte-queue reference model of the column format.
module tb_raw_column_reader;
    localparam int unsigned H     = 5;
    localparam int unsigned W     = 8;
    localparam int unsigned IW    = 16;
    localparam int unsigned COL_W = H * 3 * W;

    typedef struct {
        logic [COL_W-1:0] pix;
        logic             last;
        logic [IW-1:0]    idx;
        logic             err;
    } col_t;

    logic clock;
    logic reset_n;
    int   n_vec;
    int   n_err;
    int   sink_mode;   // 0: always ready, 1: random, 2: stalled

    col_t       exp_q[$];
    logic [7:0] cur[$];
    int         m_idx;
    bit         m_err;

    raw_column_reader_if #(.PIPELINE_HEIGHT(H), .COLOR_WIDTH(W), .INDEX_WIDTH(IW)) bus ();

    raw_column_reader #(.PIPELINE_HEIGHT(H), .COLOR_WIDTH(W), .INDEX_WIDTH(IW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: collect bytes; a column closes after 3*H bytes or on last
    function automatic void model_byte(input logic [7:0] d, input bit last);
        col_t c;
        cur.push_back(d);
        if (cur.size() == 3 * H || last) begin
            c.pix = '0;
            for (int i = 0; i < cur.size(); i++) begin
                c.pix[(i / 3) * 3 * W + (2 - i % 3) * W +: W] = cur[i];
            end
            if (last && cur.size() != 3 * H) m_err = 1'b1;
            c.err  = m_err;
            c.last = last;
            c.idx  = IW'(m_idx);
            m_idx  = last ? 0 : (m_idx + 1) % 65536;
            exp_q.push_back(c);
            cur.delete();
        end
    endfunction

    function automatic void model_reset();
        cur.delete();
        exp_q.delete();
        m_idx = 0;
        m_err = 1'b0;
    endfunction

    // Offer one byte after `gap` idle cycles; returns at posedge+1 after handshake
    task automatic send_byte(input logic [7:0] d, input bit last, input int gap, input bit no_stall);
        int waits;
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
        for (int g = 0; g < gap; g++) begin
            bus.byte_data = 8'($urandom);
            @(posedge clock); #1;
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = d;
        bus.byte_last  = last;
        waits = 0;
        @(negedge clock);
        while (!bus.byte_ready && waits < 300) begin
            waits++;
            @(negedge clock);
        end
        if (waits >= 300) begin
            check("byte_timeout", 128'(waits), 128'(0));
            bus.byte_valid = 1'b0;
            return;
        end
        if (no_stall) check("bready_stall", 128'(waits), 128'(0));
        @(posedge clock); #1;
        model_byte(d, last);
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        check("drain", 128'(exp_q.size()), 128'(0));
        @(posedge clock); #1;
    endtask

    // Sink readiness driver
    initial begin
        bus.col_ready = 1'b1;
        forever begin
            @(posedge clock); #1;
            case (sink_mode)
                0:       bus.col_ready = 1'b1;
                1:       bus.col_ready = ($urandom_range(0, 3) != 0);
                default: bus.col_ready = 1'b0;
            endcase
        end
    end

    // Column monitor: handshake seen at negedge completes on the next posedge
    always @(negedge clock) begin
        if (reset_n && bus.col_valid) begin
            if (bus.col_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_col", 128'(1), 128'(0));
                end else begin
                    col_t e;
                    e = exp_q.pop_front();
                    check("col_pixels", 128'(bus.col_pixels), 128'(e.pix));
                    check("col_last",   128'(bus.col_last),   128'(e.last));
                    check("col_index",  128'(bus.col_index),  128'(e.idx));
                    check("err_short",  128'(bus.err_short),  128'(e.err));
                end
            end else begin
                check("stall_bready", 128'(bus.byte_ready), 128'(0));
            end
        end
    end

    initial begin
        n_vec          = 0;
        n_err          = 0;
        sink_mode      = 0;
        reset_n        = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;
        bus.byte_last  = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        // Reset state
        check("rst_col_valid",  128'(bus.col_valid),  128'(0));
        check("rst_col_pixels", 128'(bus.col_pixels), 128'(0));
        check("rst_col_last",   128'(bus.col_last),   128'(0));
        check("rst_col_index",  128'(bus.col_index),  128'(0));
        check("rst_err_short",  128'(bus.err_short),  128'(0));
        check("rst_byte_ready", 128'(bus.byte_ready), 128'(1));

        // Basic column: 0x01..0x0F, last on 15th, one-cycle latency
        for (int i = 0; i < 15; i++) send_byte(8'(i + 1), i == 14, 0, 1'b1);
        check("basic_latency", 128'(bus.col_valid), 128'(1));
        drain();

        // Back-to-back three columns
        for (int i = 0; i < 45; i++) send_byte(8'($urandom), i == 44, 0, 1'b1);
        drain();

        // Backpressure: sink stalled 10 cycles after the first column loads
        sink_mode = 2;
        fork
            begin
                for (int i = 0; i < 30; i++) send_byte(8'($urandom), i == 29, 0, 1'b0);
            end
            begin
                int n = 0;
                while (!bus.col_valid && n < 200) begin
                    @(negedge clock);
                    n++;
                end
                check("bp_load_timeout", 128'(n < 200), 128'(1));
                for (int k = 0; k < 10; k++) begin
                    @(negedge clock);
                    check("bp_byte_ready", 128'(bus.byte_ready), 128'(0));
                    check("bp_col_valid",  128'(bus.col_valid),  128'(1));
                end
                sink_mode = 0;
            end
        join
        drain();

        // Short frame then a full frame: err_short stays set
        for (int i = 0; i < 7; i++) send_byte(8'(8'hA0 + i), i == 6, 0, 1'b1);
        drain();
        for (int i = 0; i < 15; i++) send_byte(8'($urandom), i == 14, 0, 1'b1);
        drain();
        check("err_sticky", 128'(bus.err_short), 128'(1));

        // Reset mid-column: partial data discarded, err and index cleared
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b0, 0, 1'b1);
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        check("rst2_col_valid", 128'(bus.col_valid), 128'(0));
        check("rst2_err_short", 128'(bus.err_short), 128'(0));
        for (int i = 0; i < 15; i++) send_byte(8'(8'h40 + i), i == 14, 0, 1'b1);
        drain();

        // Gapped input: idle cycle before every byte
        for (int i = 0; i < 15; i++) send_byte(8'(i + 1), i == 14, 1, 1'b0);
        drain();

        // Random frames with random gaps and random sink readiness
        sink_mode = 1;
        for (int f = 0; f < 12; f++) begin
            int n;
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) send_byte(8'($urandom), i == n - 1, $urandom_range(0, 2), 1'b0);
        end
        drain();
        sink_mode = 0;
        repeat (3) @(posedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/raw_column_reader.md
Name: raw_column_reader

Overview:
- Ingest side of the image pipeline: consumes a raw byte stream in the same R,G,B byte-triplet format the pipeline dumps to image.raw.
- Reassembles the bytes into PixelArray-shaped columns of PIPELINE_HEIGHT pixels for the head of the pipeline (replaces the synthetic init stage).
- Byte input and column output both use valid/ready handshakes; frame boundaries are carried by a last flag.

Parameters:
- PIPELINE_HEIGHT, 5, pixels per column (pixel 0 = top row).
- COLOR_WIDTH, 8, bits per colour channel; one channel per input byte.
- INDEX_WIDTH, 16, width of the column index counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- byte_valid  in  1  input byte present.
- byte_data  in  COLOR_WIDTH  channel value.
- byte_last  in  1  final byte of frame.
- byte_ready  out  1  byte accepted when byte_valid && byte_ready.
- col_valid  out  1  column held in output register.
- col_ready  in  1  sink accepts column.
- col_pixels  out  PIPELINE_HEIGHT*3*COLOR_WIDTH  packed column; pixel p at bits [p*3W +: 3W], red most significant, then green, then blue.
- col_last  out  1  column is final column of frame.
- col_index  out  INDEX_WIDTH  column number within frame, first column = 0.
- err_short  out  1  sticky: frame ended mid-column.

Behaviour:
- Reset (async assert, sync deassert use): col_valid=0, col_pixels=0, col_last=0, col_index=0, err_short=0. Channel pointer=R, pixel pointer=0, staging buffer=0. Reset mid-column discards the partial column, with no emission.
- byte_ready = !col_valid || col_ready. It is combinational from registered state and col_ready only, never from byte_valid or byte_last.
- Byte order:
  - Channel pointer cycles R→G→B.
  - After B, pixel pointer increments.
  - Each accepted byte is written into staging[pixel][channel].
- Column completion: accepting B of pixel PIPELINE_HEIGHT-1:
  - Loads the output register on the same edge (staging plus the incoming byte), so col_valid=1 on the next cycle. Latency is 1 cycle from the final byte handshake.
  - Pointers return to R/0 and the staging buffer clears.
- Short frame: byte_last accepted at any position other than the column-final byte:
  - Emits the column immediately (same 1-cycle latency), with all unwritten channels and pixels = 0.
  - col_last=1; err_short set (cleared only by reset); pointers reset.
- byte_last on the column-final byte: normal emission with col_last=1, err_short unchanged.
- Output register: holds col_pixels, col_last and col_index stable while col_valid && !col_ready.
- Output handshake:
  - col_valid && col_ready with no new load: col_valid=0 next cycle.
  - Simultaneous accept and new load: col_valid stays 1 with new contents (full throughput when col_ready is held high).
- col_index:
  - Value of the internal column counter captured at load.
  - Counter increments per emitted column and resets to 0 after emitting a col_last column.
  - Wraps modulo 2^INDEX_WIDTH without error.
- Throughput: with col_ready=1 permanently, one byte per cycle and no bubbles. With the sink stalled, byte_ready drops while col_valid=1, including mid-column (conservative stall by design).
- byte_data is ignored when byte_valid=0; pointers advance only on handshake.

Test Plan:
- Basic column, H=5: bytes 0x01..0x0F, byte_last on the 15th, col_ready=1.
  - col_valid rises 1 cycle after the 15th byte.
  - Pixel0 = {01,02,03}, pixel4 = {0D,0E,0F}.
  - col_last=1, col_index=0, err_short=0.
- Back-to-back: 45 bytes (3 columns), last on byte 45, col_ready=1.
  - Three columns with col_index 0,1,2; only the third has col_last=1.
  - byte_ready never drops.
- Backpressure: col_ready=0 for 10 cycles after the first column loads.
  - byte_ready=0 throughout.
  - Output stable at its loaded value; no bytes lost.
  - Second column is correct after release.
- Short frame: 7 bytes 0xA0..0xA6, byte_last on the 7th.
  - Pixel0 = {A0,A1,A2}, pixel1 = {A3,A4,A5}, pixel2 = {A6,00,00}, pixels 3–4 = 0.
  - col_last=1, err_short=1 and stays 1 through the next full frame.
- Reset mid-column: 8 bytes, then assert reset_n=0 for 2 cycles, then a clean 15-byte frame.
  - No column is emitted for the partial data.
  - The next column starts at pixel0 = first new byte; col_index=0.
- Gapped input: byte_valid toggled every other cycle over 15 bytes.
  - Same column as the basic case; pointers do not advance on idle cycles.
